// File: rtl/edge_detect_mc.sv
// edge_detect_mc: per-channel synchroniser, glitch filter and edge detector
// with sticky write-1-to-clear flags and a combined interrupt request.
// Build macro EDGE_TSTAMP_EN adds a free-running timestamp counter that is
// captured, together with the lowest pulsing channel index, on each edge event.
module edge_detect_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int TS_W        = 16,
  localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     data_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     flag_clr,
  input  logic [CH-1:0]     irq_en,
  output logic [CH-1:0]     level_out,
  output logic [CH-1:0]     edge_pulse,
  output logic [CH-1:0]     edge_flag,
`ifdef EDGE_TSTAMP_EN
  output logic              irq,
  output logic [TS_W-1:0]   ts_q,
  output logic [CHW-1:0]    ts_ch
`else
  output logic              irq
`endif
);

  logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
  logic [CH-1:0][FILT_W-1:0]      r_cnt;
  logic [CH-1:0]                  w_sync;
  logic [CH-1:0]                  r_lvl;
  logic [CH-1:0]                  r_lvl_d;
  logic [CH-1:0]                  r_flag;
  logic [CH-1:0]                  w_pulse;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser: bare shift chain per channel, stage 0 samples the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
    end
  end

  // Glitch filter: lvl only moves after filt_len consecutive differing samples.
  // The compare is done one bit wider so cnt+1 cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_sync[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if (({1'b0, r_cnt[i]} + (FILT_W+1)'(1)) >= {1'b0, filt_len}) begin
          r_lvl[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the filtered level for edge decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_d <= '0;
    end else begin
      r_lvl_d <= r_lvl;
    end
  end

  // Edge decode is combinational so a mode write acts in the same cycle.
  always_comb begin
    w_pulse = '0;
    for (int i = 0; i < CH; i++) begin
      w_pulse[i] = (mode[2*i]   &  r_lvl[i] & ~r_lvl_d[i]) |
                   (mode[2*i+1] & ~r_lvl[i] &  r_lvl_d[i]);
    end
  end

  // Sticky flags: a new pulse wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= '0;
    end else begin
      r_flag <= (r_flag & ~flag_clr) | w_pulse;
    end
  end

  assign level_out  = r_lvl;
  assign edge_pulse = w_pulse;
  assign edge_flag  = r_flag;
  assign irq        = |(r_flag & irq_en);

`ifdef EDGE_TSTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_ts_q;
  logic [CHW-1:0]  r_ts_ch;
  logic [CHW-1:0]  w_low_ch;

  // Priority pick of the lowest-numbered pulsing channel.
  always_comb begin
    w_low_ch = '0;
    for (int i = CH-1; i >= 0; i--) begin
      if (w_pulse[i]) w_low_ch = CHW'(i);
    end
  end

  // Free-running timestamp, captured on any edge event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt <= '0;
      r_ts_q   <= '0;
      r_ts_ch  <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (|w_pulse) begin
        r_ts_q  <= r_ts_cnt;
        r_ts_ch <= w_low_ch;
      end
    end
  end

  assign ts_q  = r_ts_q;
  assign ts_ch = r_ts_ch;
`endif

endmodule

// File: tb/tb_edge_detect_mc.sv
// Self-checking bench for edge_detect_mc: directed scenarios followed by
// randomized traffic, all compared against a sample-history reference model.
module tb_edge_detect_mc;
  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int QD  = 40;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   data_in;
  logic [2*NCH-1:0] mode;
  logic [3:0]       filt_len;
  logic [NCH-1:0]   flag_clr;
  logic [NCH-1:0]   irq_en;
  logic [NCH-1:0]   level_out;
  logic [NCH-1:0]   edge_pulse;
  logic [NCH-1:0]   edge_flag;
  logic             irq;
`ifdef EDGE_TSTAMP_EN
  logic [15:0]      ts_q;
  logic [1:0]       ts_ch;
  logic [15:0]      m_ts;
  logic [15:0]      m_tsq;
  logic [1:0]       m_tsch;
`endif

  edge_detect_mc #(.CH(NCH), .SYNC_STAGES(SS), .FILT_W(4), .TS_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .mode       (mode),
    .filt_len   (filt_len),
    .flag_clr   (flag_clr),
    .irq_en     (irq_en),
    .level_out  (level_out),
    .edge_pulse (edge_pulse),
    .edge_flag  (edge_flag),
`ifdef EDGE_TSTAMP_EN
    .irq        (irq),
    .ts_q       (ts_q),
    .ts_ch      (ts_ch)
`else
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: history of sampled pin vectors (newest first),
  // filtered level, previous filtered level and sticky flags.
  logic [NCH-1:0] q[$];
  logic [NCH-1:0] m_lvl;
  logic [NCH-1:0] m_lvl_d;
  logic [NCH-1:0] m_flag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A pulse fires when the level differs from last cycle and the mode
  // enables that direction.
  function automatic logic [NCH-1:0] exp_pulse(input logic [NCH-1:0] l, input logic [NCH-1:0] ld,
                                               input logic [2*NCH-1:0] md);
    logic [NCH-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) begin
      if (l[c] != ld[c]) p[c] = l[c] ? md[2*c] : md[2*c+1];
    end
    return p;
  endfunction

  task automatic model_reset();
    q = {};
    for (int j = 0; j < QD; j++) q.push_back('0);
    m_lvl = '0; m_lvl_d = '0; m_flag = '0;
`ifdef EDGE_TSTAMP_EN
    m_ts = '0; m_tsq = '0; m_tsch = '0;
`endif
  endtask

  // One clock edge of the reference. The synchronised sample seen at this
  // edge is the pin value captured SS edges ago (q[SS-1]); the level flips
  // once the trailing run of synchronised samples that disagree with it is
  // at least max(filt_len,1) long.
  task automatic model_step();
    logic [NCH-1:0] p;
    int run;
    int need;
    p = exp_pulse(m_lvl, m_lvl_d, mode);
    for (int c = 0; c < NCH; c++) begin
      if (p[c]) m_flag[c] = 1'b1;
      else if (flag_clr[c]) m_flag[c] = 1'b0;
    end
`ifdef EDGE_TSTAMP_EN
    if (p != 0) begin
      m_tsq = m_ts;
      for (int c = NCH-1; c >= 0; c--) if (p[c]) m_tsch = 2'(c);
    end
    m_ts = m_ts + 16'd1;
`endif
    m_lvl_d = m_lvl;
    need = (filt_len <= 1) ? 1 : int'(filt_len);
    for (int c = 0; c < NCH; c++) begin
      run = 0;
      while ((SS-1+run) < QD && q[SS-1+run][c] != m_lvl[c]) run++;
      if (run >= need) m_lvl[c] = ~m_lvl[c];
    end
    q.push_front(data_in);
    void'(q.pop_back());
  endtask

  task automatic check_outs();
    chk("level_out", level_out, m_lvl);
    chk("edge_pulse", edge_pulse, exp_pulse(m_lvl, m_lvl_d, mode));
    chk("edge_flag", edge_flag, m_flag);
    chk("irq", irq, |(m_flag & irq_en));
`ifdef EDGE_TSTAMP_EN
    chk("ts_q", ts_q, m_tsq);
    chk("ts_ch", ts_ch, m_tsch);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  // Asynchronous reset assert between edges; outputs must clear at once.
  task automatic do_reset(input logic [NCH-1:0] din);
    rst_n = 1'b0;
    data_in = din;
    #1;
    model_reset();
    chk("rst_level", level_out, 0);
    chk("rst_pulse", edge_pulse, 0);
    chk("rst_flag", edge_flag, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    int cnt;
    int seen;
    rst_n = 1'b1; data_in = '0; mode = '0; filt_len = '0; flag_clr = '0; irq_en = '0;
    do_reset('0);
    repeat (3) step();

    // Unfiltered rising edge on ch0: pulse SS+1 edges after the change.
    mode = 8'h01;
    data_in[0] = 1'b1;
    first = 0; cnt = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (edge_pulse[0]) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    chk("lat_ch0", first, SS + 1);
    chk("width_ch0", cnt, 1);
    chk("flag_ch0", edge_flag[0], 1'b1);
    chk("lvl_ch0", level_out[0], 1'b1);

    // Filter length 4 on ch1 in both-edge mode: short glitch rejected.
    filt_len = 4'd4;
    mode = 8'h0D;
    cnt = 0; seen = 0;
    data_in[1] = 1'b1;
    repeat (3) begin step(); cnt += int'(edge_pulse[1]); seen |= int'(level_out[1]); end
    data_in[1] = 1'b0;
    repeat (10) begin step(); cnt += int'(edge_pulse[1]); seen |= int'(level_out[1]); end
    chk("glitch_pulses", cnt, 0);
    chk("glitch_level", seen, 0);
    data_in[1] = 1'b1;
    repeat (6) begin step(); cnt += int'(edge_pulse[1]); end
    data_in[1] = 1'b0;
    repeat (15) begin step(); cnt += int'(edge_pulse[1]); end
    chk("long_pulses", cnt, 2);

    // Set and clear together on ch2: set wins, then a lone clear works.
    filt_len = 4'd0;
    mode = 8'h1D;
    irq_en = 4'b0100;
    data_in[2] = 1'b1;
    repeat (SS + 1) step();
    chk("pulse_ch2", edge_pulse[2], 1'b1);
    flag_clr = 4'b0100;
    step();
    chk("setclr_flag", edge_flag[2], 1'b1);
    chk("setclr_irq", irq, 1'b1);
    step();
    chk("clr_flag", edge_flag[2], 1'b0);
    chk("clr_irq", irq, 1'b0);
    flag_clr = '0;

    // Mode off on ch3: level follows, no pulse, no flag.
    cnt = 0; seen = 0;
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) data_in[3] = ~data_in[3];
      step();
      cnt += int'(edge_pulse[3]);
      seen |= int'(level_out[3]);
    end
    chk("off_pulses", cnt, 0);
    chk("off_flag", edge_flag[3], 1'b0);
    chk("off_level_seen", seen, 1);

    // Inputs high through reset: all channels pulse SS+1 edges after release.
    mode = 8'h55;
    do_reset(4'hF);
    first = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (edge_pulse == 4'hF && first == 0) first = n;
    end
    chk("rst_high_lat", first, SS + 1);

    // Reset in the middle of a filter count, released with inputs low.
    filt_len = 4'd8;
    data_in = '0;
    repeat (SS + 3) step();
    #3;
    do_reset('0);
    repeat (8) step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 3) == 0) data_in[c] = ~data_in[c];
      flag_clr = 4'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) filt_len = 4'($urandom_range(0, 6));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
